// File: rtl/cart_header_decoder.sv
// cart_header_decoder: snoops the ROM download stream, captures the cartridge
// header bytes, verifies the header checksum and, once the download ends,
// latches the mapper selects and sizing masks consumed by the mapper block.
// All configuration outputs stay constant between downloads.
module cart_header_decoder #(
  parameter logic [15:0] HDR_BASE   = 16'h0100,
  parameter int          ROM_MASK_W = 9
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [15:0]           ioctl_dout,
  output logic                  cfg_valid,
  output logic                  cfg_done,
  output logic                  header_ok,
  output logic [7:0]            cart_mbc_type,
  output logic                  mbc1,
  output logic                  mbc2,
  output logic                  mbc3,
  output logic                  mbc30,
  output logic                  mbc5,
  output logic                  mbc6,
  output logic                  mbc7,
  output logic                  mmm01,
  output logic                  huc1,
  output logic                  huc3,
  output logic                  gb_camera,
  output logic                  tama,
  output logic [ROM_MASK_W-1:0] rom_mask,
  output logic [3:0]            ram_mask,
  output logic                  has_ram,
  output logic                  isGBC_game
);

  // Absolute byte addresses of the header words we care about.
  localparam logic [24:0] A_134 = 25'(HDR_BASE) + 25'h034;
  localparam logic [24:0] A_142 = 25'(HDR_BASE) + 25'h042;
  localparam logic [24:0] A_146 = 25'(HDR_BASE) + 25'h046;
  localparam logic [24:0] A_148 = 25'(HDR_BASE) + 25'h048;
  localparam logic [24:0] A_14A = 25'(HDR_BASE) + 25'h04A;
  localparam logic [24:0] A_14C = 25'(HDR_BASE) + 25'h04C;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_LATCH   = 2'd2
  } state_t;

  // Mapper select vector bit order (MSB first):
  // mbc1 mbc2 mbc3 mbc30 mbc5 mbc6 mbc7 mmm01 huc1 huc3 gb_camera tama
  state_t                  state_q, state_d;
  logic                    dl_q, dl_d;
  logic                    pend_q, pend_d;
  logic [7:0]              acc_q, acc_d;
  logic [7:0]              b143_q, b143_d;
  logic [7:0]              b147_q, b147_d;
  logic [7:0]              b148_q, b148_d;
  logic [7:0]              b149_q, b149_d;
  logic [7:0]              b14d_q, b14d_d;
  logic                    cfg_valid_q, cfg_valid_d;
  logic                    cfg_done_q, cfg_done_d;
  logic                    header_ok_q, header_ok_d;
  logic [7:0]              type_q, type_d;
  logic [11:0]             map_q, map_d;
  logic [ROM_MASK_W-1:0]   rom_q, rom_d;
  logic [3:0]              ram_q, ram_d;
  logic                    has_ram_q, has_ram_d;
  logic                    gbc_q, gbc_d;

  logic                    dl_rise, dl_fall;
  logic [11:0]             map_dec;
  logic [15:0]             rom_wide;
  logic [ROM_MASK_W-1:0]   rom_dec;
  logic [3:0]              ram_dec;
  logic                    has_ram_dec;
  logic                    ok_dec;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  // Header decode from the captured bytes; only sampled into outputs in LATCH.
  always_comb begin
    map_dec  = '0;
    rom_wide = 16'd511;
    ram_dec  = 4'd15;
    if (b147_q inside {[8'h01:8'h03]}) map_dec[11] = 1'b1;
    if (b147_q inside {[8'h05:8'h06]}) map_dec[10] = 1'b1;
    if (b147_q inside {[8'h0F:8'h13]}) map_dec[9]  = 1'b1;
    if (b147_q inside {[8'h19:8'h1E]}) map_dec[7]  = 1'b1;
    if (b147_q == 8'h20)               map_dec[6]  = 1'b1;
    if (b147_q == 8'h22)               map_dec[5]  = 1'b1;
    if (b147_q inside {[8'h0B:8'h0D]}) map_dec[4]  = 1'b1;
    if (b147_q == 8'hFF)               map_dec[3]  = 1'b1;
    if (b147_q == 8'hFE)               map_dec[2]  = 1'b1;
    if (b147_q == 8'hFC)               map_dec[1]  = 1'b1;
    if (b147_q == 8'hFD)               map_dec[0]  = 1'b1;
    // MBC30 is an MBC3 with the larger RAM or ROM configuration.
    map_dec[8] = map_dec[9] & ((b149_q == 8'h05) | (b148_q == 8'h07));

    if (b148_q <= 8'd8)
      rom_wide = (16'd2 << b148_q[3:0]) - 16'd1;
    else if (b148_q inside {[8'h52:8'h54]})
      rom_wide = 16'd127;

    case (b149_q)
      8'h00, 8'h01, 8'h02: ram_dec = 4'd0;
      8'h03:               ram_dec = 4'd3;
      8'h04:               ram_dec = 4'd15;
      8'h05:               ram_dec = 4'd7;
      default:             ram_dec = 4'd15;
    endcase

    rom_dec     = rom_wide[ROM_MASK_W-1:0];
    has_ram_dec = (b149_q != 8'h00) | map_dec[10];
    ok_dec      = (acc_q == b14d_q);
  end

  // Next-state logic: edge detection, header capture, checksum and latching.
  always_comb begin
    state_d     = state_q;
    dl_d        = ioctl_download;
    pend_d      = pend_q;
    acc_d       = acc_q;
    b143_d      = b143_q;
    b147_d      = b147_q;
    b148_d      = b148_q;
    b149_d      = b149_q;
    b14d_d      = b14d_q;
    cfg_valid_d = cfg_valid_q;
    cfg_done_d  = 1'b0;
    header_ok_d = header_ok_q;
    type_d      = type_q;
    map_d       = map_q;
    rom_d       = rom_q;
    ram_d       = ram_q;
    has_ram_d   = has_ram_q;
    gbc_d       = gbc_q;

    case (state_q)
      S_IDLE: begin
        if (dl_rise | pend_q) begin
          state_d     = S_CAPTURE;
          pend_d      = 1'b0;
          cfg_valid_d = 1'b0;
          acc_d       = 8'h00;
          b143_d      = 8'h00;
          b147_d      = 8'h00;
          b148_d      = 8'h00;
          b149_d      = 8'h00;
          b14d_d      = 8'h00;
        end
      end
      S_CAPTURE: begin
        if (ioctl_wr) begin
          if (ioctl_addr == A_142) b143_d = ioctl_dout[15:8];
          if (ioctl_addr == A_146) b147_d = ioctl_dout[15:8];
          if (ioctl_addr == A_148) begin
            b148_d = ioctl_dout[7:0];
            b149_d = ioctl_dout[15:8];
          end
          if (ioctl_addr == A_14C) begin
            b14d_d = ioctl_dout[15:8];
            acc_d  = acc_q - ioctl_dout[7:0] - 8'd1;
          end
          // Every write in the checksummed range counts, repeats included.
          if ((ioctl_addr >= A_134) && (ioctl_addr <= A_14A))
            acc_d = acc_q - ioctl_dout[7:0] - ioctl_dout[15:8] - 8'd2;
        end
        if (dl_fall) state_d = S_LATCH;
      end
      S_LATCH: begin
        state_d     = S_IDLE;
        cfg_valid_d = 1'b1;
        cfg_done_d  = 1'b1;
        header_ok_d = ok_dec;
        type_d      = b147_q;
        map_d       = map_dec;
        rom_d       = rom_dec;
        ram_d       = ram_dec;
        has_ram_d   = has_ram_dec;
        gbc_d       = b143_q[7];
        // A download starting right now is serviced from IDLE next cycle.
        if (dl_rise) pend_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. The download sample resets high so that a
  // download still in progress when reset releases is not seen as a new one.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b1;
      pend_q      <= 1'b0;
      acc_q       <= 8'h00;
      b143_q      <= 8'h00;
      b147_q      <= 8'h00;
      b148_q      <= 8'h00;
      b149_q      <= 8'h00;
      b14d_q      <= 8'h00;
      cfg_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      header_ok_q <= 1'b0;
      type_q      <= 8'h00;
      map_q       <= '0;
      rom_q       <= '0;
      ram_q       <= 4'd0;
      has_ram_q   <= 1'b0;
      gbc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      b143_q      <= b143_d;
      b147_q      <= b147_d;
      b148_q      <= b148_d;
      b149_q      <= b149_d;
      b14d_q      <= b14d_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_done_q  <= cfg_done_d;
      header_ok_q <= header_ok_d;
      type_q      <= type_d;
      map_q       <= map_d;
      rom_q       <= rom_d;
      ram_q       <= ram_d;
      has_ram_q   <= has_ram_d;
      gbc_q       <= gbc_d;
    end
  end

  assign cfg_valid     = cfg_valid_q;
  assign cfg_done      = cfg_done_q;
  assign header_ok     = header_ok_q;
  assign cart_mbc_type = type_q;
  assign mbc1          = map_q[11];
  assign mbc2          = map_q[10];
  assign mbc3          = map_q[9];
  assign mbc30         = map_q[8];
  assign mbc5          = map_q[7];
  assign mbc6          = map_q[6];
  assign mbc7          = map_q[5];
  assign mmm01         = map_q[4];
  assign huc1          = map_q[3];
  assign huc3          = map_q[2];
  assign gb_camera     = map_q[1];
  assign tama          = map_q[0];
  assign rom_mask      = rom_q;
  assign ram_mask      = ram_q;
  assign has_ram       = has_ram_q;
  assign isGBC_game    = gbc_q;

endmodule

// File: tb/tb_cart_header_decoder.sv
// Testbench for cart_header_decoder: downloads random ROM images with chosen
// header fields and compares the latched configuration with a reference
// computed from the header rules (standard per-byte header checksum).
module tb_cart_header_decoder;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        cfg_valid, cfg_done, header_ok;
  logic [7:0]  cart_mbc_type;
  logic        mbc1, mbc2, mbc3, mbc30, mbc5, mbc6, mbc7, mmm01;
  logic        huc1, huc3, gb_camera, tama;
  logic [8:0]  rom_mask;
  logic [3:0]  ram_mask;
  logic        has_ram, isGBC_game;

  always #5 clk_sys = ~clk_sys;

  cart_header_decoder dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cfg_valid(cfg_valid), .cfg_done(cfg_done), .header_ok(header_ok),
    .cart_mbc_type(cart_mbc_type),
    .mbc1(mbc1), .mbc2(mbc2), .mbc3(mbc3), .mbc30(mbc30), .mbc5(mbc5),
    .mbc6(mbc6), .mbc7(mbc7), .mmm01(mmm01), .huc1(huc1), .huc3(huc3),
    .gb_camera(gb_camera), .tama(tama),
    .rom_mask(rom_mask), .ram_mask(ram_mask), .has_ram(has_ram),
    .isGBC_game(isGBC_game)
  );

  // Observed mapper selects, same bit order as the expected vector below.
  logic [11:0] map_obs;
  assign map_obs = {mbc1, mbc2, mbc3, mbc30, mbc5, mbc6, mbc7, mmm01,
                    huc1, huc3, gb_camera, tama};

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  img [0:383];
  logic [7:0]  e_type;
  logic [11:0] e_map;
  logic [8:0]  e_rom;
  logic [3:0]  e_ram;
  logic        e_has, e_gbc, e_ok;
  logic [7:0]  held_type;
  logic [8:0]  held_rom;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Standard cartridge header checksum: x = x - byte - 1 over 0x134..0x14C.
  function automatic logic [7:0] hdr_sum();
    logic [7:0] x = 8'h00;
    for (int i = 'h134; i <= 'h14C; i++) x = x - img[i] - 8'd1;
    return x;
  endfunction

  function automatic logic [11:0] ref_map(input logic [7:0] t, input logic [7:0] r, input logic [7:0] m);
    logic [11:0] v = '0;
    int ti = int'(t);
    if (ti >= 'h01 && ti <= 'h03) v[11] = 1'b1;
    if (ti >= 'h05 && ti <= 'h06) v[10] = 1'b1;
    if (ti >= 'h0F && ti <= 'h13) v[9]  = 1'b1;
    if (ti >= 'h19 && ti <= 'h1E) v[7]  = 1'b1;
    if (ti == 'h20) v[6] = 1'b1;
    if (ti == 'h22) v[5] = 1'b1;
    if (ti >= 'h0B && ti <= 'h0D) v[4]  = 1'b1;
    if (ti == 'hFF) v[3] = 1'b1;
    if (ti == 'hFE) v[2] = 1'b1;
    if (ti == 'hFC) v[1] = 1'b1;
    if (ti == 'hFD) v[0] = 1'b1;
    if (v[9] && (m == 8'd5 || r == 8'd7)) v[8] = 1'b1;
    return v;
  endfunction

  function automatic logic [8:0] ref_rom(input logic [7:0] r);
    int n = int'(r);
    if (n <= 8) return 9'((2 ** (n + 1)) - 1);
    if (n >= 'h52 && n <= 'h54) return 9'd127;
    return 9'd511;
  endfunction

  function automatic logic [3:0] ref_ram(input logic [7:0] m);
    case (int'(m))
      0, 1, 2: return 4'd0;
      3:       return 4'd3;
      5:       return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  // Build a random image with the given header fields and its expected config.
  task automatic build(input logic [7:0] t, input logic [7:0] r, input logic [7:0] m,
                       input logic [7:0] g, input bit corrupt);
    for (int i = 0; i < 384; i++) img[i] = 8'($urandom);
    img['h143] = g;
    img['h147] = t;
    img['h148] = r;
    img['h149] = m;
    img['h14D] = hdr_sum();
    if (corrupt) img['h140] = img['h140] + 8'd1;
    e_type = t;
    e_map  = ref_map(t, r, m);
    e_rom  = ref_rom(r);
    e_ram  = ref_ram(m);
    e_has  = (m != 8'h00) || e_map[10];
    e_gbc  = g[7];
    e_ok   = (hdr_sum() == img['h14D]);
  endtask

  task automatic check_cfg(input string tag);
    chk({tag, ".valid"}, cfg_valid, 1);
    chk({tag, ".type"}, cart_mbc_type, e_type);
    chk({tag, ".map"}, map_obs, e_map);
    chk({tag, ".rom"}, rom_mask, e_rom);
    chk({tag, ".ram"}, ram_mask, e_ram);
    chk({tag, ".has_ram"}, has_ram, e_has);
    chk({tag, ".gbc"}, isGBC_game, e_gbc);
    chk({tag, ".ok"}, header_ok, e_ok);
  endtask

  task automatic download(input string tag);
    ioctl_download = 1'b1;
    tick();
    tick();
    chk({tag, ".valid_drop"}, cfg_valid, 0);
    chk({tag, ".hold_type"}, cart_mbc_type, held_type);
    chk({tag, ".hold_rom"}, rom_mask, held_rom);
    for (int a = 0; a < 384; a += 2) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = {img[a+1], img[a]};
      tick();
    end
    ioctl_wr = 1'b0;
    chk({tag, ".hold_end"}, cart_mbc_type, held_type);
    ioctl_download = 1'b0;
    tick();
    chk({tag, ".done_early"}, cfg_done, 0);
    tick();
    chk({tag, ".done_pulse"}, cfg_done, 1);
    check_cfg(tag);
    tick();
    chk({tag, ".done_width"}, cfg_done, 0);
    held_type = e_type;
    held_rom  = e_rom;
    $display("download %s: type=%02h rom=%0d ram=%0d ok=%0b", tag, e_type, e_rom, e_ram, e_ok);
  endtask

  initial begin
    logic [7:0] t, r, m;
    logic [7:0] picks [0:11];
    int seen;
    picks = '{8'h01, 8'h05, 8'h0C, 8'h0F, 8'h13, 8'h1B, 8'h20, 8'h22, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    held_type = 8'h00; held_rom = 9'd0;
    #1;
    chk("rst.valid", cfg_valid, 0);
    chk("rst.done", cfg_done, 0);
    chk("rst.map", map_obs, 0);
    chk("rst.rom", rom_mask, 0);
    chk("rst.ram", {has_ram, ram_mask, isGBC_game, header_ok}, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    build(8'h1B, 8'h05, 8'h03, 8'h00, 1'b0);
    download("mbc5");

    // Reset in the middle of a download.
    build(8'h10, 8'h07, 8'h05, 8'h80, 1'b0);
    ioctl_download = 1'b1;
    tick(); tick();
    for (int a = 'h100; a < 'h14A; a += 2) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = {img[a+1], img[a]};
      tick();
    end
    ioctl_wr = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstmid.valid", cfg_valid, 0);
    chk("rstmid.type", cart_mbc_type, 0);
    chk("rstmid.map", map_obs, 0);
    chk("rstmid.rom", rom_mask, 0);
    chk("rstmid.ram", {has_ram, ram_mask, isGBC_game, header_ok}, 0);
    #2 reset_n = 1'b1;
    tick();
    ioctl_download = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cfg_done) seen++;
    end
    chk("rstmid.no_done", seen, 0);
    chk("rstmid.valid_after", cfg_valid, 0);
    held_type = 8'h00; held_rom = 9'd0;

    build(8'h10, 8'h07, 8'h05, 8'h80, 1'b0);
    download("mbc30");
    build(8'h06, 8'($urandom_range(0, 8)), 8'h00, 8'h00, 1'b0);
    download("mbc2");
    build(8'h00, 8'h02, 8'h02, 8'h00, 1'b0);
    download("none");
    build(8'h13, 8'h53, 8'h04, 8'h00, 1'b1);
    download("corrupt");
    // Back-to-back downloads of different types.
    build(8'h01, 8'h01, 8'h01, 8'h00, 1'b0);
    download("b2b_a");
    build(8'hFF, 8'h08, 8'h03, 8'h80, 1'b0);
    download("b2b_b");

    for (int k = 0; k < 8; k++) begin
      t = ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 11)] : 8'($urandom);
      case ($urandom_range(0, 2))
        0:       r = 8'($urandom_range(0, 8));
        1:       r = 8'($urandom_range('h52, 'h54));
        default: r = 8'($urandom);
      endcase
      m = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      build(t, r, m, 8'($urandom), 1'($urandom_range(0, 1)));
      download($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
